// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and helpers for the gshare/bimodal direction predictor.
package bp_pkg;

  localparam int unsigned BP_IDX_MAX = 16;
  localparam logic [2:0]  BR_NONE    = 3'd0;

  // Index field is sized for the widest supported table; users cast to their own width.
  typedef struct packed {
    logic [BP_IDX_MAX-1:0] index;
    logic                  pred;
  } bp_entry_t;

  function automatic int unsigned ctr_update(input int unsigned ctr,
                                             input logic        taken,
                                             input int unsigned ctr_max);
    int unsigned res;
    res = ctr;
    if (taken) begin
      if (ctr < ctr_max) res = ctr + 1;
    end else begin
      if (ctr != 0) res = ctr - 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_pending_fifo.sv
// In-order queue of unresolved predictions; pointer MSB distinguishes full from empty.
module bp_pending_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      clear_i,
  input  bp_entry_t din_i,
  output logic      full_o,
  output logic      empty_o,
  output bp_entry_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  bp_entry_t   mem_q [DEPTH];

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      rd_d = wr_q;
    end else begin
      if (push_i) wr_d = wr_q + PTR_ONE;
      if (pop_i)  rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Direction predictor: saturating-counter table indexed by PC (optionally XOR speculative GHR),
// with in-order resolution, history recovery on mispredict/flush, and miss statistics.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned CTR_INIT    = 1,
  parameter int unsigned GHR_BITS    = 6,
  parameter int unsigned GSHARE      = 1,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] lookup_pc_low,
  input  logic [2:0]            lookup_branch_type,
  output logic                  predict_taken,
  output logic                  queue_full,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  output logic                  mispredict,
  input  logic                  flush,
  output logic [31:0]           branch_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam int unsigned CTR_MAX = (2 ** CTR_BITS) - 1;

  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [GHR_BITS-1:0]   spec_ghr_q, spec_ghr_d, arch_ghr_q, arch_ghr_d;
  logic                  mispredict_q;
  logic [31:0]           branch_cnt_q, miss_cnt_q;

  logic [INDEX_BITS-1:0] lookup_idx, head_idx;
  logic [CTR_BITS-1:0]   ctr_new;
  logic                  is_branch, fifo_full, fifo_empty;
  logic                  do_pop, do_push, miss, squash;
  bp_entry_t             push_ent, head_ent;

  assign is_branch     = (lookup_branch_type != BR_NONE);
  assign lookup_idx    = (GSHARE != 0) ? (lookup_pc_low ^ INDEX_BITS'(spec_ghr_q)) : lookup_pc_low;
  assign predict_taken = is_branch && !fifo_full && ctr_q[lookup_idx][CTR_BITS-1];
  assign queue_full    = fifo_full;
  assign head_idx      = INDEX_BITS'(head_ent.index);

  // Resolution is handled before any squash; a squash always drops the same-cycle push.
  assign do_pop  = resolve_valid && !fifo_empty;
  assign miss    = do_pop && (resolve_taken != head_ent.pred);
  assign squash  = flush || miss;
  assign do_push = is_branch && (!fifo_full || do_pop) && !squash;

  always_comb begin
    push_ent       = '0;
    push_ent.index = BP_IDX_MAX'(lookup_idx);
    push_ent.pred  = predict_taken;
    ctr_new        = CTR_BITS'(ctr_update(32'(ctr_q[head_idx]), resolve_taken, CTR_MAX));
    arch_ghr_d     = arch_ghr_q;
    if (do_pop) arch_ghr_d = {arch_ghr_q[GHR_BITS-2:0], resolve_taken};
    spec_ghr_d     = spec_ghr_q;
    if (squash)       spec_ghr_d = arch_ghr_d;
    else if (do_push) spec_ghr_d = {spec_ghr_q[GHR_BITS-2:0], predict_taken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_BITS'(CTR_INIT);
      spec_ghr_q   <= '0;
      arch_ghr_q   <= '0;
      mispredict_q <= 1'b0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (do_pop) begin
        ctr_q[head_idx] <= ctr_new;
        branch_cnt_q    <= branch_cnt_q + 32'd1;
      end
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      mispredict_q <= miss;
    end
  end

  assign mispredict   = mispredict_q;
  assign branch_count = branch_cnt_q;
  assign miss_count   = miss_cnt_q;

  bp_pending_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .clear_i (squash),
    .din_i   (push_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_ent)
  );

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised direction predictor for ID stage; successor to the 64-entry 2-bit bimodal predictor.
- Adds configurable table depth and counter width, bimodal/gshare mode, and a speculative global history register (GHR) with recovery.
- Adds an in-order pending-prediction queue for multiple in-flight branches, plus training on every resolved branch rather than only on mispredicts.
- Resolution arrives in program order from EX/MEM; the block exposes mispredict statistics.

Parameters:
- INDEX_BITS, 6, table index width; table has 2**INDEX_BITS counters.
- CTR_BITS, 2, saturating counter width (>=2); MSB=1 means predict taken.
- CTR_INIT, 1, reset value of every counter (01 = weakly not-taken).
- GHR_BITS, 6, history length; must be <= INDEX_BITS.
- GSHARE, 1, 1 = index is pc_low XOR zero-extended GHR; 0 = pure bimodal (GHR still maintained).
- QUEUE_DEPTH, 4, max unresolved predictions (power of 2, >=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_pc_low  in  INDEX_BITS  low PC bits of the ID instruction.
- lookup_branch_type  in  3  nonzero = conditional branch present.
- predict_taken  out  1  combinational prediction for the current lookup; 0 when branch_type==0 or queue full.
- queue_full  out  1  pending queue full; ID must stall a branch while high.
- resolve_valid  in  1  oldest pending branch resolved this cycle.
- resolve_taken  in  1  actual outcome of that branch.
- mispredict  out  1  registered pulse, one cycle after a resolve whose outcome != stored prediction.
- flush  in  1  squash all pending predictions (exception/redirect).
- branch_count  out  32  resolved branches since reset; wraps.
- miss_count  out  32  mispredicted resolutions since reset; wraps.

Behaviour:
- Reset (async): counters=CTR_INIT, spec_ghr=arch_ghr=0, queue empty, mispredict=0, both counts=0. A reset asserted mid-operation discards all pending entries immediately.
- Index = GSHARE ? pc_low ^ spec_ghr : pc_low.
- predict_taken = (branch_type!=0) && !queue_full && table[index][MSB]. It is a zero-latency read of the registered table. A same-cycle update to the same index is not forwarded; the lookup sees the old value.
- Push: when branch_type!=0 and the queue is not full (or is full with a same-cycle pop), enqueue {index, predict_taken} and set spec_ghr <= {spec_ghr[GHR_BITS-2:0], predict_taken}.
- Pop: on resolve_valid with a non-empty queue, dequeue the head.
  - Counter at head index moves toward resolve_taken, saturating at 0 and 2**CTR_BITS-1.
  - arch_ghr <= {arch_ghr[GHR_BITS-2:0], resolve_taken}.
  - branch_count increments.
  - If resolve_taken != head prediction: miss_count increments, mispredict=1 next cycle, all younger entries are squashed, spec_ghr <= updated arch_ghr, and any same-cycle push is dropped.
- resolve_valid with an empty queue is ignored: no update, no count, no pulse.
- flush: the queue empties and spec_ghr <= arch_ghr. If a resolve occurs in the same cycle, the head is processed first (counter, arch_ghr, counts). spec_ghr then takes the post-update arch_ghr. A same-cycle push is dropped.
- Precedence in one cycle: rst > resolve processing > flush/mispredict squash > push.
- Queue pointers are log2(QUEUE_DEPTH)+1 bits. full/empty are derived from the MSB; wrap-around is natural.

Decomposition:
- Package bp_pkg holds:
  - typedef of the pending entry {index, pred};
  - function ctr_update(ctr, taken) for saturating increment/decrement;
  - the branch-type constant BR_NONE=3'd0.
- One sub-module, bp_pending_fifo: parametrised synchronous FIFO with push, pop, clear, full, empty and head outputs, with async reset.

Test Plan:
- Reset then lookup pc_low=5, type=1 -> predict_taken=0; after resolving taken twice, the next lookup of the same index (GSHARE=0) -> predict_taken=1.
- GSHARE=0: 4 taken resolves at index 9 -> counter saturates at 3; a 5th taken leaves 3; 2 not-taken resolves -> counter=1, predict 0.
- Push 4 branches (QUEUE_DEPTH=4) -> queue_full=1 and predict_taken=0. Same-cycle resolve+push -> push accepted, full stays 1.
- Pending preds {1,1,1}; resolve head taken=0 -> mispredict pulse next cycle, miss_count=1, queue empty, spec_ghr==arch_ghr.
- GSHARE=1: GHR=6'b000011, pc_low=6'b000101 -> index 6'b000110 updated. Flush with 3 pending -> spec_ghr restored to arch_ghr.
- Assert rst while 2 entries are pending and counters are trained -> all counters=CTR_INIT, counts=0, queue_full=0; a resolve on the empty queue after reset changes nothing.
